emulador_teclado: RTL and testbench

EMULADOR_TECLADO -- requirements
Module: emulador_teclado

---
 rtl/emulador_teclado.sv | 155 +++++++++++++++
 tb/tb_emulador_teclado.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/emulador_teclado.sv
// Keypad matrix emulator: presses one key of a 4x4 row-scanned keypad per request,
// with optional contact bounce, a timed hold and a forced release gap.
module emulador_teclado #(
  parameter int HOLD_CYCLES   = 540000,
  parameter int GAP_CYCLES    = 270000,
  parameter int BOUNCE_CYCLES = 0,
  parameter int BOUNCE_PERIOD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  localparam logic [23:0] L_HOLD   = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] L_GAP    = 24'(GAP_CYCLES - 1);
  localparam logic [23:0] L_BOUNCE = 24'(BOUNCE_CYCLES - 1);
  localparam logic [23:0] L_BPER   = 24'(BOUNCE_PERIOD - 1);
  localparam logic        L_HAS_BOUNCE = (BOUNCE_CYCLES > 0);
  localparam logic        L_GAP_ONE    = (GAP_CYCLES == 1);

  state_t      r_state;
  logic [23:0] r_cnt;
  logic [23:0] r_bph;
  logic        r_contact;
  logic        r_done;
  logic [1:0]  r_row;
  logic [1:0]  r_col;
  logic [3:0]  w_cols;

  // Row-major map, returns {row, col}; '*' is E and '#' is F on the bottom row.
  function automatic logic [3:0] map_key(input logic [3:0] code);
    logic [3:0] rc;
    case (code)
      4'h1: rc = {2'd0, 2'd0};
      4'h2: rc = {2'd0, 2'd1};
      4'h3: rc = {2'd0, 2'd2};
      4'hA: rc = {2'd0, 2'd3};
      4'h4: rc = {2'd1, 2'd0};
      4'h5: rc = {2'd1, 2'd1};
      4'h6: rc = {2'd1, 2'd2};
      4'hB: rc = {2'd1, 2'd3};
      4'h7: rc = {2'd2, 2'd0};
      4'h8: rc = {2'd2, 2'd1};
      4'h9: rc = {2'd2, 2'd2};
      4'hC: rc = {2'd2, 2'd3};
      4'hE: rc = {2'd3, 2'd0};
      4'h0: rc = {2'd3, 2'd1};
      4'hF: rc = {2'd3, 2'd2};
      4'hD: rc = {2'd3, 2'd3};
      default: rc = 4'd0;
    endcase
    return rc;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 24'd0;
      r_bph     <= 24'd0;
      r_contact <= 1'b0;
      r_done    <= 1'b0;
      r_row     <= 2'd0;
      r_col     <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (key_valid) begin
            {r_row, r_col} <= map_key(key_code);
            r_contact      <= 1'b1;
            if (L_HAS_BOUNCE) begin
              r_state <= ST_BOUNCE;
              r_cnt   <= L_BOUNCE;
              r_bph   <= L_BPER;
            end else begin
              r_state <= ST_HOLD;
              r_cnt   <= L_HOLD;
            end
          end
        end
        ST_BOUNCE: begin
          if (r_cnt == 24'd0) begin
            r_state   <= ST_HOLD;
            r_cnt     <= L_HOLD;
            r_contact <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 24'd1;
            // Contact flips once per bounce period, starting closed.
            if (r_bph == 24'd0) begin
              r_contact <= ~r_contact;
              r_bph     <= L_BPER;
            end else begin
              r_bph <= r_bph - 24'd1;
            end
          end
        end
        ST_HOLD: begin
          if (r_cnt == 24'd0) begin
            r_state   <= ST_GAP;
            r_cnt     <= L_GAP;
            r_contact <= 1'b0;
            r_done    <= L_GAP_ONE;
          end else begin
            r_cnt <= r_cnt - 24'd1;
          end
        end
        ST_GAP: begin
          if (r_cnt == 24'd0) begin
            r_state <= ST_IDLE;
            r_cnt   <= 24'd0;
            r_done  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt - 24'd1;
            r_done <= (r_cnt == 24'd1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= 24'd0;
          r_contact <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  // Matrix path: the closed contact shorts the latched row onto the latched column.
  always_comb begin
    w_cols = 4'b1111;
    if (r_contact && !filas[r_row]) begin
      w_cols[r_col] = 1'b0;
    end else begin
      w_cols = 4'b1111;
    end
  end

  assign columnas  = w_cols;
  assign key_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_emulador_teclado.sv
// Directed self-checking bench for emulador_teclado: one instance without bounce
// (HOLD=8, GAP=4) and one with BOUNCE_CYCLES=32, BOUNCE_PERIOD=8.
module tb_emulador_teclado;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] filas = 4'b0000;
  logic [3:0] key_code = 4'h0;
  logic       key_valid = 1'b0;
  logic [3:0] columnas;
  logic       key_ready, busy, done;

  logic [3:0] b_filas = 4'b0111;
  logic [3:0] b_key_code = 4'h0;
  logic       b_key_valid = 1'b0;
  logic [3:0] b_columnas;
  logic       b_key_ready, b_busy, b_done;

  int n_err = 0;
  int n_chk = 0;

  logic [3:0] keymap [0:15] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

  always #5 clk = ~clk;

  emulador_teclado #(.HOLD_CYCLES(8), .GAP_CYCLES(4), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(16)) u_dut (
    .clk(clk), .rst(rst), .filas(filas), .columnas(columnas), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .busy(busy), .done(done));

  emulador_teclado #(.HOLD_CYCLES(8), .GAP_CYCLES(4), .BOUNCE_CYCLES(32), .BOUNCE_PERIOD(8)) u_dut_b (
    .clk(clk), .rst(rst), .filas(b_filas), .columnas(b_columnas), .key_code(b_key_code),
    .key_valid(b_key_valid), .key_ready(b_key_ready), .busy(b_busy), .done(b_done));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected column lines for a key, contact state and row drive.
  function automatic logic [3:0] exp_cols(input logic [3:0] code, input logic closed, input logic [3:0] f);
    logic [3:0] res;
    res = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      if (keymap[i] == code && closed && !f[i / 4]) res[i % 4] = 1'b0;
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full press on the non-bounce instance; filas cycles through p[0..3].
  task automatic press_a(input string tag, input logic [3:0] code, input logic [3:0] p0,
                         input logic [3:0] p1, input logic [3:0] p2, input logic [3:0] p3);
    logic [3:0] pat [0:3];
    pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
    check_eq({tag, "_ready"}, 32'(key_ready), 32'd1);
    key_code  = code;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key_code  = ~code;
    for (int k = 0; k < 12; k++) begin
      filas = pat[k % 4];
      #1;
      check_eq({tag, "_col"}, 32'(columnas), 32'(exp_cols(code, k < 8, filas)));
      check_eq({tag, "_done"}, 32'(done), 32'(k == 11));
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
    end
    check_eq({tag, "_end_ready"}, 32'(key_ready), 32'd1);
    check_eq({tag, "_end_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    // Reset state, with every row driven low so an open contact is visible.
    tick(); tick();
    check_eq("rst_col", 32'(columnas), 32'hF);
    check_eq("rst_ready", 32'(key_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_b_col", 32'(b_columnas), 32'hF);
    @(negedge clk);
    rst = 1'b0;
    tick();

    press_a("k5_scan", 4'h5, 4'b1110, 4'b1101, 4'b1011, 4'b0111);
    press_a("kD_held", 4'hD, 4'b0111, 4'b0111, 4'b0111, 4'b0111);
    press_a("kA_noscan", 4'hA, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
    press_a("k6_multi", 4'h6, 4'b0000, 4'b1010, 4'b0101, 4'b1011);

    // Back-to-back requests with key_valid held high.
    filas     = 4'b1110;
    key_code  = 4'h1;
    key_valid = 1'b1;
    tick();
    key_code = 4'h2;
    for (int k = 0; k < 12; k++) begin
      check_eq("b2b_first_col", 32'(columnas), 32'(exp_cols(4'h1, k < 8, filas)));
      check_eq("b2b_first_done", 32'(done), 32'(k == 11));
      check_eq("b2b_first_ready", 32'(key_ready), 32'd0);
      tick();
    end
    check_eq("b2b_idle_ready", 32'(key_ready), 32'd1);
    tick();
    key_valid = 1'b0;
    check_eq("b2b_second_busy", 32'(busy), 32'd1);
    check_eq("b2b_second_col", 32'(columnas), 32'b1101);
    for (int k = 1; k < 12; k++) begin
      tick();
      check_eq("b2b_second_done", 32'(done), 32'(k == 11));
    end
    tick();
    check_eq("b2b_second_end", 32'(key_ready), 32'd1);

    // Reset three cycles into HOLD, then a clean press of 0x9.
    filas     = 4'b1011;
    key_code  = 4'h9;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick(); tick();
    check_eq("rstmid_pre_col", 32'(columnas), 32'b1011);
    rst = 1'b1;
    #1;
    check_eq("rstmid_col", 32'(columnas), 32'hF);
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rstmid_ready", 32'(key_ready), 32'd1);
    press_a("k9_after_rst", 4'h9, 4'b1011, 4'b1011, 4'b1011, 4'b1011);

    // Bounce instance: 32 bounce cycles toggling every 8, then 8 hold, 4 gap.
    b_key_code  = 4'h0;
    b_key_valid = 1'b1;
    tick();
    b_key_valid = 1'b0;
    for (int k = 0; k < 44; k++) begin
      check_eq("bounce_col", 32'(b_columnas),
               32'(exp_cols(4'h0, (k < 32) ? ((k / 8) % 2 == 0) : (k < 40), b_filas)));
      check_eq("bounce_done", 32'(b_done), 32'(k == 43));
      tick();
    end
    check_eq("bounce_end_ready", 32'(b_key_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
